// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit with HI:LO result registers.
// Multiply and divide each take 32 iterations plus one sign-fix cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_is_div;
  logic        r_dz;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed;
  logic        w_diff_sign;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_step;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [63:0] w_div_step;

  function automatic logic [31:0] abs32(input logic [31:0] x, input logic en);
    abs32 = (en && x[31]) ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] x, input logic en);
    neg32 = en ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x, input logic en);
    neg64 = en ? (~x + 64'd1) : x;
  endfunction

  assign w_signed    = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
  assign w_diff_sign = w_signed && (A[31] ^ B[31]);
  assign w_a_mag     = abs32(A, w_signed);
  assign w_b_mag     = abs32(B, w_signed);

  // Multiply: accumulator holds {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_step = {w_mul_sum, r_acc[31:1]};

  // Divide: accumulator holds {remainder, dividend/quotient}; trial is 33 bits wide.
  assign w_div_ge   = r_acc[63:31] >= {1'b0, r_opnd};
  assign w_div_sub  = r_acc[62:31] - r_opnd;
  assign w_div_step = w_div_ge ? {w_div_sub, r_acc[30:0], 1'b1}
                               : {r_acc[62:0], 1'b0};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && (MDUOp == OP_MULT || MDUOp == OP_MULTU)) w_state_nxt = S_MUL;
        else if (start && (MDUOp == OP_DIV || MDUOp == OP_DIVU)) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (r_cnt == 5'd31) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (MDUOp)
              OP_MULT, OP_MULTU: begin
                r_acc    <= {32'd0, w_b_mag};
                r_opnd   <= w_a_mag;
                r_neg_q  <= w_diff_sign;
                r_neg_r  <= 1'b0;
                r_is_div <= 1'b0;
                r_dz     <= 1'b0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                r_acc    <= {32'd0, w_a_mag};
                r_opnd   <= w_b_mag;
                r_neg_q  <= w_diff_sign;
                r_neg_r  <= w_signed && A[31];
                r_is_div <= 1'b1;
                r_dz     <= (B == 32'd0);
                r_cnt    <= '0;
                r_busy   <= 1'b1;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_acc <= w_mul_step;
          r_cnt <= r_cnt + 5'd1;
        end
        S_DIV: begin
          r_acc <= w_div_step;
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_is_div) begin
            // Remainder already equals A when dividing by zero; only the quotient needs forcing.
            r_lo <= r_dz ? 32'hFFFF_FFFF : neg32(r_acc[31:0], r_neg_q);
            r_hi <= neg32(r_acc[63:32], r_neg_r);
          end else begin
            {r_hi, r_lo} <= neg64(r_acc, r_neg_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  muldiv_unit dut (
    .clk(clk), .rstn(rstn), .start(start), .MDUOp(MDUOp), .A(A), .B(B),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic with the architectural special cases.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb_v;
    logic [63:0] p;
    int ia, ib;
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin
        sa   = longint'(signed'(a));
        sb_v = longint'(signed'(b));
        p = sa * sb_v;
        {hi, lo} = p;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        {hi, lo} = p;
      end
      3'd2: begin
        ia = a;
        ib = b;
        if (b == 0) begin
          lo = 32'hFFFF_FFFF; hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = 32'd0;
        end else begin
          lo = ia / ib; hi = ia % ib;
        end
      end
      3'd3: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF; hi = a;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_hi", {32'd0, HI}, {32'd0, e.hi});
        check("result_lo", {32'd0, LO}, {32'd0, e.lo});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; MDUOp = op; A = a; B = b;
    if (op <= 3'd3) begin
      model(op, a, b, e.hi, e.lo);
      e.cyc = cyc + 34;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    MDUOp = 3'($urandom_range(0, 7));
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Full operation with busy/hold checks along the way.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi0, lo0;
    @(negedge clk);
    hi0 = HI; lo0 = LO;
    issue(op, a, b);
    check("busy_start", {63'd0, busy}, 64'd1);
    repeat (20) @(posedge clk);
    #1;
    check("busy_mid", {63'd0, busy}, 64'd1);
    check("hold_hilo", {HI, LO}, {hi0, lo0});
    repeat (12) @(posedge clk);
    #1;
    check("busy_last", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    check("busy_end", {63'd0, busy}, 64'd0);
    wait_idle();
  endtask

  logic [31:0] ehi, elo, ra, rb;
  logic [2:0]  rop;

  initial begin
    rstn = 1'b0; start = 1'b0; MDUOp = '0; A = '0; B = '0;
    #12;
    check("reset_state", {28'd0, busy, done, 2'b00, HI}, 64'd0);
    check("reset_lo", {32'd0, LO}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op(3'd3, 32'h0000_0064, 32'h0000_0000);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd2, 32'h0000_0007, 32'hFFFF_FFFE);

    // MTHI / MTLO take effect at the start edge without busy or done.
    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_hi", {32'd0, HI}, 64'h1234_5678);
    check("mthi_flags", {62'd0, busy, done}, 64'd0);
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    check("mtlo_lo", {HI, LO}, 64'h1234_5678_CAFE_F00D);

    // Reserved opcode leaves everything untouched.
    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    check("reserved_hilo", {HI, LO}, 64'h1234_5678_CAFE_F00D);
    check("reserved_busy", {63'd0, busy}, 64'd0);

    // Second start while busy is ignored.
    model(3'd1, 32'h0001_0003, 32'h0002_0005, ehi, elo);
    issue(3'd1, 32'h0001_0003, 32'h0002_0005);
    repeat (4) @(posedge clk);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    wait_idle();
    check("hazard_hilo", {HI, LO}, {ehi, elo});

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb);
    end

    // Reset in the middle of a divide abandons it.
    issue(3'd2, 32'h0000_1000, 32'h0000_0003);
    repeat (9) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midreset_flags", {62'd0, busy, done}, 64'd0);
    check("midreset_hilo", {HI, LO}, 64'd0);
    sb.delete();
    @(posedge clk); #1 rstn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("postreset_hilo", {HI, LO}, 64'd0);

    // First edge after reset release accepts a start.
    @(negedge clk);
    rstn = 1'b0;
    #2 rstn = 1'b1;
    model(3'd3, 32'd100, 32'd7, ehi, elo);
    start = 1'b1; MDUOp = 3'd3; A = 32'd100; B = 32'd7;
    begin
      exp_t e;
      e.hi = ehi; e.lo = elo; e.cyc = cyc + 34;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("first_edge_busy", {63'd0, busy}, 64'd1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands and 64-bit HI:LO.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request strobe, sampled on the rising edge of clk.
REQ-006 MDUOp  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-007 A  input  32  multiplicand / dividend / MTHI-MTLO source.
REQ-008 B  input  32  multiplier / divisor.
REQ-009 busy  output  1  high while a multiply or divide is in progress.
REQ-010 done  output  1  one-cycle pulse when HI/LO receive a multiply or divide result.
REQ-011 HI  output  32  HI register, driven directly from the register.
REQ-012 LO  output  32  LO register, driven directly from the register.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV and FIX; state and all outputs SHALL be registered.
REQ-014 In IDLE with start=1 and MDUOp 0-3, the block SHALL do the following at that edge N:
- latch |A| and |B| (signed ops) or A and B (unsigned ops);
- latch the result signs;
- clear the iteration counter;
- enter MUL (ops 0-1) or DIV (ops 2-3);
- set busy=1.
REQ-015 MUL SHALL run exactly 32 cycles of one-bit shift-add on a 64-bit accumulator; DIV SHALL run exactly 32 cycles of one-bit restoring division (33-bit trial subtract).
REQ-016 Counter wrap SHALL be handled as follows: after the 32nd iteration the block SHALL enter FIX; FIX SHALL last one cycle.
REQ-017 FIX SHALL apply sign correction, write HI/LO, set done=1 and busy=0 at edge N+33, and return to IDLE.
REQ-018 Latency SHALL be 33 cycles from the start edge to the HI/LO update.
REQ-019 done SHALL be high for exactly the cycle after edge N+33.
REQ-020 HI/LO SHALL hold their previous values throughout MUL and DIV.
REQ-021 MULT/MULTU results SHALL be {HI,LO} = the 64-bit product; for MULT, the magnitude product SHALL be negated when A[31]^B[31]=1.
REQ-022 DIV/DIVU results SHALL be LO = quotient and HI = remainder.
REQ-023 For DIV, the quotient SHALL be negated when A[31]^B[31]=1, and the remainder SHALL take the sign of A (truncation toward zero).
REQ-024 Divide by zero (B=0, DIV or DIVU) SHALL still take 33 cycles and produce LO=0xFFFFFFFF, HI=A.
REQ-025 The DIV of 0x80000000 by 0xFFFFFFFF SHALL produce LO=0x80000000, HI=0x00000000; no trap SHALL be raised.
REQ-026 MTHI/MTLO with start=1 in IDLE SHALL write A into HI/LO at that edge, leave busy=0 and done=0, and stay in IDLE.
REQ-027 start SHALL be ignored while busy=1 or in FIX, including MTHI/MTLO; A, B and MDUOp SHALL be don't-care after the start edge.
REQ-028 Reserved MDUOp 6-7 with start=1 SHALL cause no state or output change.
REQ-029 When done and a new start coincide in the same cycle (FIX→IDLE edge), the start SHALL be ignored; the earliest accepted start SHALL be in the cycle after done.

Reset
REQ-030 rstn=0 SHALL immediately force state=IDLE, busy=0, done=0, HI=0, LO=0, counter=0, and accumulators=0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL abandon the operation with no HI/LO update and no done pulse.
REQ-032 After rstn deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-033 MULT, A=0xFFFFFFFF, B=0x00000002 -> busy for 33 cycles, done pulses once, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-034 MULTU, same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-035 DIV, A=0xFFFFFFF9 (-7), B=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 DIVU, A=0x00000064, B=0 -> LO=0xFFFFFFFF, HI=0x00000064; DIV of 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 Hazard and reset sequence:
- MTHI with A=0x12345678 in IDLE -> HI=0x12345678 next edge, done stays 0;
- MULTU start, then second start 5 cycles later -> second start ignored, single done;
- rstn=0 at cycle 10 of a DIV -> busy=0, HI=LO=0 immediately, no done.
